// File: rtl/apb_master_nslv.sv
// apb_master_nslv: APB master bridge with an address-decoded fabric of NUM_SLV slaves.
// A CPU data-port request (transfer strobe) becomes one APB SETUP/ACCESS transfer. The CPU
// then holds until a one-cycle ready pulse returns rdata and an error flag.
//
// Ports:
//   PCLK, PRESET             clock (rising edge) and asynchronous active-low reset
//   transfer, write          CPU request strobe (sampled in IDLE only) and direction
//   addr, wdata              CPU byte address and write data, latched with the request
//   rdata, ready, error      completion pulse with read data and error status
//   PADDR, PWDATA, PWRITE    APB address/data/direction, held from SETUP through ACCESS
//   PENABLE, PSEL            APB enable and one-hot slave select
//   PRDATA, PREADY, PSLVERR  flat per-slave response buses (slave i at slice i)
module apb_master_nslv #(
   parameter int unsigned       NUM_SLV     = 8,
   parameter int unsigned       ADDR_W      = 32,
   parameter int unsigned       DATA_W      = 32,
   parameter logic [ADDR_W-1:0] SLV_BASE    = 32'h1000_0000,
   parameter int unsigned       SLV_SZ_LOG2 = 12,
   parameter int unsigned       TIMEOUT     = 16
) (
   input  logic                      PCLK,
   input  logic                      PRESET,
   input  logic                      transfer,
   input  logic                      write,
   input  logic [ADDR_W-1:0]         addr,
   input  logic [DATA_W-1:0]         wdata,
   output logic [DATA_W-1:0]         rdata,
   output logic                      ready,
   output logic                      error,
   output logic [ADDR_W-1:0]         PADDR,
   output logic [DATA_W-1:0]         PWDATA,
   output logic                      PWRITE,
   output logic                      PENABLE,
   output logic [NUM_SLV-1:0]        PSEL,
   input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
   input  logic [NUM_SLV-1:0]        PREADY,
   input  logic [NUM_SLV-1:0]        PSLVERR
);

   localparam int unsigned IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
   // Counter only needs to reach TIMEOUT-1; it simply wraps when TIMEOUT is 0.
   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                write_q, write_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                error_q, error_d;

   // Address decode of the live CPU address, used only when a request is accepted.
   logic [ADDR_W-1:0]   dec_off;
   logic [ADDR_W-1:0]   dec_win;
   logic                dec_mapped;

   always_comb begin
      dec_off    = addr - SLV_BASE;
      dec_win    = dec_off >> SLV_SZ_LOG2;
      // The lower-bound test rejects addresses whose subtraction wrapped around.
      dec_mapped = (addr >= SLV_BASE) && (dec_win < ADDR_W'(NUM_SLV));
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      write_d = write_q;
      idx_d   = idx_q;
      cnt_d   = '0;
      rdata_d = rdata_q;
      error_d = error_q;
      unique case (state_q)
         StIdle: begin
            if (transfer) begin
               addr_d  = addr;
               wdata_d = wdata;
               write_d = write;
               if (dec_mapped) begin
                  idx_d   = dec_win[IDX_W-1:0];
                  state_d = StSetup;
               end else begin
                  rdata_d = '0;
                  error_d = 1'b1;
                  state_d = StDone;
               end
            end
         end
         StSetup: begin
            state_d = StAccess;
         end
         StAccess: begin
            cnt_d = cnt_q + 1'b1;
            if (PREADY[idx_q]) begin
               rdata_d = write_q ? '0 : PRDATA[idx_q*DATA_W +: DATA_W];
               error_d = PSLVERR[idx_q];
               state_d = StDone;
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
               rdata_d = '0;
               error_d = 1'b1;
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         state_q <= StIdle;
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         idx_q   <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         error_q <= error_d;
      end
   end

   // Outputs decode straight from the state register, so an asynchronous reset drops
   // PSEL/PENABLE without waiting for a clock edge.
   always_comb begin
      PSEL = '0;
      if ((state_q == StSetup) || (state_q == StAccess)) begin
         PSEL[idx_q] = 1'b1;
      end
      PENABLE = (state_q == StAccess);
      ready   = (state_q == StDone);
      rdata   = ready ? rdata_q : '0;
      error   = ready ? error_q : 1'b0;
      PADDR   = addr_q;
      PWDATA  = wdata_q;
      PWRITE  = write_q;
   end

endmodule

// File: tb/tb_apb_master_nslv.sv
// Scoreboard bench for apb_master_nslv: each transfer pushes its expected completion
// (rdata, error, latency) and the monitor pops and compares it when ready appears.
module tb_apb_master_nslv;

   logic          PCLK = 1'b0;
   logic          PRESET = 1'b0;
   logic          transfer = 1'b0;
   logic          write = 1'b0;
   logic [31:0]   addr = '0;
   logic [31:0]   wdata = '0;
   logic [31:0]   rdata;
   logic          ready;
   logic          error;
   logic [31:0]   PADDR;
   logic [31:0]   PWDATA;
   logic          PWRITE;
   logic          PENABLE;
   logic [7:0]    PSEL;
   logic [255:0]  PRDATA;
   logic [7:0]    PREADY;
   logic [7:0]    PSLVERR;

   // Slave model knobs
   logic [31:0]   slv_rd [8];
   int            wait_cfg = 0;
   int            acc_cnt = 0;
   logic [7:0]    err_mask = '0;
   logic [7:0]    noise_rdy = '0;

   int            n_vec = 0;
   int            n_err = 0;

   typedef struct {
      logic [31:0] rd;
      logic        err;
      int          lat;
   } exp_t;
   exp_t sb[$];

   apb_master_nslv dut (
      .PCLK     (PCLK),
      .PRESET   (PRESET),
      .transfer (transfer),
      .write    (write),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .ready    (ready),
      .error    (error),
      .PADDR    (PADDR),
      .PWDATA   (PWDATA),
      .PWRITE   (PWRITE),
      .PENABLE  (PENABLE),
      .PSEL     (PSEL),
      .PRDATA   (PRDATA),
      .PREADY   (PREADY),
      .PSLVERR  (PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   always @(posedge PCLK) acc_cnt <= PENABLE ? acc_cnt + 1 : 0;

   assign PREADY  = ((PENABLE && (acc_cnt == wait_cfg)) ? PSEL : 8'h00) | noise_rdy;
   assign PSLVERR = err_mask;

   always_comb begin
      PRDATA = '0;
      for (int i = 0; i < 8; i++) PRDATA[i*32 +: 32] = slv_rd[i];
   end

   task automatic run_xfer(input string name, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rd,
                           input logic exp_err, input int exp_lat, input logic [7:0] exp_psel);
      int          cyc;
      logic        got;
      logic [7:0]  psel_seen;
      logic        bus_bad;
      logic [31:0] rd;
      logic        er;
      exp_t        e;
      sb.push_back('{rd: exp_rd, err: exp_err, lat: exp_lat});
      @(negedge PCLK);
      transfer = 1'b1; write = w; addr = a; wdata = d;
      @(negedge PCLK);
      transfer = 1'b0;
      cyc = 1; got = 1'b0; psel_seen = '0; bus_bad = 1'b0; rd = '0; er = 1'b0;
      while (!got && cyc <= 64) begin
         psel_seen |= PSEL;
         if ($countones(PSEL) > 1 || (PENABLE && PSEL == 8'h00)) bus_bad = 1'b1;
         if (PSEL != 8'h00 && (PADDR !== a || PWRITE !== w || PWDATA !== d)) bus_bad = 1'b1;
         if (ready) begin
            got = 1'b1; rd = rdata; er = error;
            if (PSEL != 8'h00 || PENABLE) bus_bad = 1'b1;
         end else begin
            @(negedge PCLK);
            cyc++;
         end
      end
      e = sb.pop_front();
      n_vec++;
      if (!got) begin
         n_err++;
         $display("FAIL %s ready_timeout: no ready within %0d cycles, required at %0d",
                  name, cyc, e.lat);
      end else begin
         n_vec += 3;
         if (cyc !== e.lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d required %0d", name, cyc, e.lat);
         end
         if (rd !== e.rd) begin
            n_err++;
            $display("FAIL %s rdata: got %h required %h", name, rd, e.rd);
         end
         if (er !== e.err) begin
            n_err++;
            $display("FAIL %s error: got %b required %b", name, er, e.err);
         end
      end
      n_vec += 2;
      if (psel_seen !== exp_psel) begin
         n_err++;
         $display("FAIL %s psel: got %h required %h", name, psel_seen, exp_psel);
      end
      if (bus_bad !== 1'b0) begin
         n_err++;
         $display("FAIL %s bus_protocol: got bad=%b required 0", name, bus_bad);
      end
      @(negedge PCLK);
      n_vec++;
      if (ready !== 1'b0) begin
         n_err++;
         $display("FAIL %s ready_pulse: got %b required 0", name, ready);
      end
   endtask

   task automatic test_reset();
      logic [31:0] snap [8];
      transfer = 1'b1; addr = 32'h1000_0000;
      repeat (3) @(negedge PCLK);
      snap[0] = rdata; snap[1] = {31'd0, ready}; snap[2] = {31'd0, error};
      snap[3] = PADDR; snap[4] = PWDATA; snap[5] = {31'd0, PWRITE};
      snap[6] = {31'd0, PENABLE}; snap[7] = {24'd0, PSEL};
      for (int i = 0; i < 8; i++) begin
         n_vec++;
         if (snap[i] !== 32'd0) begin
            n_err++;
            $display("FAIL reset_out%0d: got %h required 0", i, snap[i]);
         end
      end
      transfer = 1'b0; addr = '0;
      PRESET = 1'b1;
      @(negedge PCLK);
   endtask

   task automatic test_write_zero_wait();
      wait_cfg = 0; err_mask = 8'h80;
      run_xfer("wr_slv0", 1'b1, 32'h1000_0004, 32'hA5A5_0001, 32'h0, 1'b0, 3, 8'h01);
      err_mask = 8'h00;
   endtask

   task automatic test_read_wait();
      wait_cfg = 3; noise_rdy = 8'h08; slv_rd[5] = 32'h0000_1234;
      run_xfer("rd_slv5_wait3", 1'b0, 32'h1000_5010, 32'h0, 32'h0000_1234, 1'b0, 6, 8'h20);
      noise_rdy = 8'h00; wait_cfg = 0;
   endtask

   task automatic test_unmapped();
      run_xfer("unmapped_hi", 1'b0, 32'h2000_0000, 32'h0, 32'h0, 1'b1, 1, 8'h00);
      run_xfer("unmapped_end", 1'b0, 32'h1000_8000, 32'h0, 32'h0, 1'b1, 1, 8'h00);
      run_xfer("unmapped_lo", 1'b1, 32'h0FFF_FFFC, 32'h1, 32'h0, 1'b1, 1, 8'h00);
      run_xfer("last_window", 1'b0, 32'h1000_7FFC, 32'h0, 32'hDEAD_0007, 1'b0, 3, 8'h80);
   endtask

   task automatic test_timeout();
      wait_cfg = 1000;
      run_xfer("timeout_slv6", 1'b0, 32'h1000_6000, 32'h0, 32'h0, 1'b1, 18, 8'h40);
      wait_cfg = 0;
   endtask

   task automatic test_slverr();
      err_mask = 8'h80; noise_rdy = 8'h08;
      run_xfer("slverr_slv7", 1'b1, 32'h1000_7008, 32'h5555_AAAA, 32'h0, 1'b1, 3, 8'h80);
      err_mask = 8'h00; noise_rdy = 8'h00;
   endtask

   task automatic test_reset_mid();
      logic saw_ready;
      wait_cfg = 1000;
      @(negedge PCLK);
      transfer = 1'b1; write = 1'b0; addr = 32'h1000_2000;
      @(negedge PCLK);
      transfer = 1'b0;
      @(negedge PCLK);
      n_vec++;
      if (PSEL !== 8'h04 || PENABLE !== 1'b1) begin
         n_err++;
         $display("FAIL midrst_access: got psel=%h en=%b required 04/1", PSEL, PENABLE);
      end
      @(posedge PCLK);
      #2 PRESET = 1'b0;
      #1;
      n_vec++;
      if (PSEL !== 8'h00 || PENABLE !== 1'b0) begin
         n_err++;
         $display("FAIL midrst_drop: got psel=%h en=%b required 00/0", PSEL, PENABLE);
      end
      saw_ready = 1'b0;
      repeat (2) begin
         @(negedge PCLK);
         if (ready) saw_ready = 1'b1;
      end
      PRESET = 1'b1;
      wait_cfg = 0;
      repeat (3) begin
         @(negedge PCLK);
         if (ready) saw_ready = 1'b1;
      end
      n_vec++;
      if (saw_ready !== 1'b0) begin
         n_err++;
         $display("FAIL midrst_no_ready: got %b required 0", saw_ready);
      end
      run_xfer("after_reset", 1'b0, 32'h1000_2000, 32'h0, 32'hDEAD_0002, 1'b0, 3, 8'h04);
   endtask

   task automatic test_back_to_back();
      run_xfer("b2b_wr", 1'b1, 32'h1000_3000, 32'hCAFE_0003, 32'h0, 1'b0, 3, 8'h08);
      run_xfer("b2b_rd", 1'b0, 32'h1000_1FF0, 32'h0, 32'hDEAD_0001, 1'b0, 3, 8'h02);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) slv_rd[i] = 32'hDEAD_0000 + 32'(i);
      test_reset();
      test_write_zero_wait();
      test_read_wait();
      test_unmapped();
      test_timeout();
      test_slverr();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
